// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Load-use / outstanding-load hazard detector with an in-order tag
//            FIFO of destination registers for a variable-latency data memory.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter  int MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_inst_id,
    input  logic             i_id_valid,
    input  logic [31:0]      i_inst_ex,
    input  logic             i_ex_valid,
    input  logic             i_ex_fire,
    input  logic             i_flush,
    input  logic             i_load_resp_valid,
    output logic             o_stall,
    output logic [4:0]       o_resp_rd,
    output logic [31:0]      o_pending_mask,
    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_err_overflow,
    output logic             o_err_underflow
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_REG    = 7'b0110011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] C_LAST    = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W:0]   C_MAX_EXT = (CNT_W + 1)'(MAX_OUT);

    // A slot is zeroed when popped, so an empty FIFO holds only x0 tags.
    logic [4:0]       r_rd [MAX_OUT];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err_ovf;
    logic             r_err_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_ex_load;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [31:0]      w_pending;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_ex_rd;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_str;
    logic             w_unused;

    assign w_full    = (r_count == C_MAX);
    assign w_empty   = (r_count == '0);
    assign w_ex_load = i_ex_valid && (i_inst_ex[6:0] == C_OP_LOAD);
    assign w_push    = w_ex_load && i_ex_fire && !w_full;
    assign w_pop     = i_load_resp_valid && !w_empty;
    assign w_wr_nxt  = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt  = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                r_rd[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            // Push and pop never target the same slot: that needs full or empty.
            if (w_push) begin
                r_rd[r_wr_ptr] <= i_inst_ex[11:7];
                r_wr_ptr       <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd[r_rd_ptr] <= '0;
                r_rd_ptr       <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_err_ovf <= w_ex_load && i_ex_fire && w_full;
            r_err_udf <= i_load_resp_valid && w_empty;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            w_pending[r_rd[i]] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    always_comb begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        case (i_inst_id[6:0])
            C_OP_REG, C_OP_STORE, C_OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            C_OP_IMM, C_OP_LOAD, C_OP_JALR: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b0;
            end
            C_OP_LUI, C_OP_AUIPC, C_OP_JAL: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
            default: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
        endcase
    end

    assign w_rs1   = i_inst_id[19:15];
    assign w_rs2   = i_inst_id[24:20];
    assign w_ex_rd = i_inst_ex[11:7];

    assign w_raw1 = (w_rs1 != 5'd0) && ((w_ex_load && (w_ex_rd == w_rs1)) || w_pending[w_rs1]);
    assign w_raw2 = (w_rs2 != 5'd0) && ((w_ex_load && (w_ex_rd == w_rs2)) || w_pending[w_rs2]);
    // A load in EX will claim a slot before the ID load can reach dmem.
    assign w_str  = (i_inst_id[6:0] == C_OP_LOAD) &&
                    (({1'b0, r_count} + (CNT_W + 1)'(w_ex_load)) >= C_MAX_EXT);

    assign o_stall         = i_id_valid && !i_flush &&
                             ((w_use_rs1 && w_raw1) || (w_use_rs2 && w_raw2) || w_str);
    assign o_resp_rd       = r_rd[r_rd_ptr];
    assign o_pending_mask  = w_pending;
    assign o_outstanding   = r_count;
    assign o_err_overflow  = r_err_ovf;
    assign o_err_underflow = r_err_udf;

    assign w_unused = &{1'b0, i_inst_ex[31:12], i_inst_id[31:25], i_inst_id[14:7]};

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed bench for hazard_scoreboard, MAX_OUT=4 and MAX_OUT=2 side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_id;
    logic        id_valid;
    logic [31:0] inst_ex;
    logic        ex_valid;
    logic        ex_fire;
    logic        flush;
    logic        resp_valid;

    logic        stall4,  stall2;
    logic [4:0]  rrd4,    rrd2;
    logic [31:0] pend4,   pend2;
    logic [2:0]  out4;
    logic [1:0]  out2;
    logic        ovf4,    ovf2;
    logic        udf4,    udf2;

    int total;
    int bad;

    hazard_scoreboard #(.MAX_OUT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_inst_id(inst_id), .i_id_valid(id_valid),
        .i_inst_ex(inst_ex), .i_ex_valid(ex_valid), .i_ex_fire(ex_fire),
        .i_flush(flush), .i_load_resp_valid(resp_valid),
        .o_stall(stall4), .o_resp_rd(rrd4), .o_pending_mask(pend4),
        .o_outstanding(out4), .o_err_overflow(ovf4), .o_err_underflow(udf4)
    );

    hazard_scoreboard #(.MAX_OUT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_inst_id(inst_id), .i_id_valid(id_valid),
        .i_inst_ex(inst_ex), .i_ex_valid(ex_valid), .i_ex_fire(ex_fire),
        .i_flush(flush), .i_load_resp_valid(resp_valid),
        .o_stall(stall2), .o_resp_rd(rrd2), .o_pending_mask(pend2),
        .o_outstanding(out2), .o_err_overflow(ovf2), .o_err_underflow(udf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] f_lui(input logic [4:0] rd);
        return {20'h12345, rd, 7'b0110111};
    endfunction

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_id    = C_NOP;
        id_valid   = 1'b0;
        inst_ex    = C_NOP;
        ex_valid   = 1'b0;
        ex_fire    = 1'b0;
        flush      = 1'b0;
        resp_valid = 1'b0;
    endtask

    task automatic fire_load(input logic [4:0] rd);
        inst_ex  = f_lw(rd, 5'd1);
        ex_valid = 1'b1;
        ex_fire  = 1'b1;
        tick();
        ex_valid = 1'b0;
        ex_fire  = 1'b0;
    endtask

    task automatic respond();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        do_reset();

        // reset state
        id_valid = 1'b1;
        inst_id  = f_add(5'd6, 5'd5, 5'd2);
        #1;
        chk("rst_stall",  {31'd0, stall4}, 32'd0);
        chk("rst_out4",   {29'd0, out4},   32'd0);
        chk("rst_out2",   {30'd0, out2},   32'd0);
        chk("rst_pend",   pend4,           32'd0);
        chk("rst_resprd", {27'd0, rrd4},   32'd0);
        chk("rst_errs",   {28'd0, ovf4, udf4, ovf2, udf2}, 32'd0);
        idle();
        tick();

        // 1: load-use against EX
        inst_ex  = f_lw(5'd5, 5'd1);
        ex_valid = 1'b1;
        id_valid = 1'b1;
        inst_id  = f_add(5'd6, 5'd5, 5'd2);
        #1;
        chk("t1_ex_raw", {31'd0, stall4}, 32'd1);
        inst_id = f_add(5'd6, 5'd2, 5'd5);
        #1;
        chk("t1_ex_raw_rs2", {31'd0, stall4}, 32'd1);
        flush = 1'b1;
        #1;
        chk("t1_flush", {31'd0, stall4}, 32'd0);
        flush   = 1'b0;
        inst_id = f_lui(5'd5);
        #1;
        chk("t1_lui", {31'd0, stall4}, 32'd0);
        idle();
        tick();

        // 2: outstanding LW x7, SW x7 waits for response
        id_valid = 1'b1;
        fire_load(5'd7);
        inst_id = f_sw(5'd7, 5'd3);
        #1;
        chk("t2_stall_c1", {31'd0, stall4}, 32'd1);
        chk("t2_pend7",    pend4,           32'h0000_0080);
        chk("t2_out",      {29'd0, out4},   32'd1);
        tick();
        chk("t2_stall_c2", {31'd0, stall4}, 32'd1);
        tick();
        chk("t2_stall_c3", {31'd0, stall4}, 32'd1);
        resp_valid = 1'b1;
        #1;
        chk("t2_resp_rd",    {27'd0, rrd4},   32'd7);
        chk("t2_no_bypass",  {31'd0, stall4}, 32'd1);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("t2_stall_clr", {31'd0, stall4}, 32'd0);
        chk("t2_pend_clr",  pend4,           32'd0);
        idle();
        tick();

        // 3: structural stall, MAX_OUT=2
        fire_load(5'd8);
        fire_load(5'd9);
        id_valid = 1'b1;
        inst_id  = f_lw(5'd10, 5'd1);
        #1;
        chk("t3_str_stall2", {31'd0, stall2}, 32'd1);
        chk("t3_out2",       {30'd0, out2},   32'd2);
        chk("t3_no_str4",    {31'd0, stall4}, 32'd0);
        chk("t3_pend",       pend2,           32'h0000_0300);
        resp_valid = 1'b1;
        #1;
        chk("t3_resp_rd8", {27'd0, rrd2},   32'd8);
        chk("t3_stall_resp_cyc", {31'd0, stall2}, 32'd1);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("t3_stall_free", {31'd0, stall2}, 32'd0);
        chk("t3_resp_rd9",   {27'd0, rrd2},   32'd9);
        inst_ex  = f_lw(5'd11, 5'd1);
        ex_valid = 1'b1;
        #1;
        chk("t3_str_ex_load", {31'd0, stall2}, 32'd1);
        ex_valid = 1'b0;
        respond();
        chk("t3_drained", {30'd0, out2}, 32'd0);
        idle();
        tick();

        // 4: duplicate rd
        fire_load(5'd4);
        fire_load(5'd4);
        chk("t4_pend_both", pend4, 32'h0000_0010);
        respond();
        chk("t4_pend_one",  pend4,         32'h0000_0010);
        chk("t4_out_one",   {29'd0, out4}, 32'd1);
        respond();
        chk("t4_pend_none", pend4,         32'd0);
        idle();
        tick();

        // 5: full + pop + fire -> no push, overflow pulse
        fire_load(5'd11);
        fire_load(5'd12);
        inst_ex    = f_lw(5'd13, 5'd1);
        ex_valid   = 1'b1;
        ex_fire    = 1'b1;
        resp_valid = 1'b1;
        tick();
        idle();
        #1;
        chk("t5_ovf2",     {31'd0, ovf2},   32'd1);
        chk("t5_out2",     {30'd0, out2},   32'd1);
        chk("t5_head2",    {27'd0, rrd2},   32'd12);
        chk("t5_pend2",    pend2,           32'h0000_1000);
        chk("t5_ovf4",     {31'd0, ovf4},   32'd0);
        chk("t5_out4",     {29'd0, out4},   32'd2);
        chk("t5_pend4",    pend4,           32'h0000_3000);
        tick();
        chk("t5_ovf_pulse", {31'd0, ovf2}, 32'd0);
        do_reset();

        // 6: underflow, x0 load, async reset
        respond();
        chk("t6_udf",     {31'd0, udf4},  32'd1);
        chk("t6_udf_out", {29'd0, out4},  32'd0);
        tick();
        chk("t6_udf_pulse", {31'd0, udf4}, 32'd0);
        inst_ex  = f_lw(5'd0, 5'd1);
        ex_valid = 1'b1;
        id_valid = 1'b1;
        inst_id  = f_add(5'd6, 5'd0, 5'd0);
        #1;
        chk("t6_x0_ex", {31'd0, stall4}, 32'd0);
        ex_fire = 1'b1;
        tick();
        ex_valid = 1'b0;
        ex_fire  = 1'b0;
        #1;
        chk("t6_x0_pend",  pend4,           32'd0);
        chk("t6_x0_out",   {29'd0, out4},   32'd1);
        chk("t6_x0_stall", {31'd0, stall4}, 32'd0);
        id_valid = 1'b0;
        fire_load(5'd20);
        fire_load(5'd21);
        chk("t6_three_out",  {29'd0, out4}, 32'd3);
        chk("t6_three_pend", pend4,         32'h0030_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out",  {29'd0, out4}, 32'd0);
        chk("t6_async_pend", pend4,         32'd0);
        chk("t6_async_out2", {30'd0, out2}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
